// File: rtl/event_unit_pkg.sv
// Shared types and constants for the event-unit SoC event FIFO slice.
package event_unit_pkg;

  localparam int EVT_ID_W               = 8;
  localparam int FIFO_MODE_BACKPRESSURE = 0;
  localparam int FIFO_MODE_DROP         = 1;

  // Pop response as seen on pop_rdata: hit=0 means the FIFO was empty.
  typedef struct packed {
    logic                hit;
    logic [EVT_ID_W-1:0] id;
  } evt_resp_t;

endpackage

// File: rtl/event_unit_soc_evt_fifo_if.sv
// SoC event push link plus the per-core pop port of the event FIFO.
interface event_unit_soc_evt_fifo_if #(
  parameter int NB_CORES   = 8,
  parameter int EVNT_WIDTH = 8
);

  logic                  evt_valid_i;
  logic                  evt_ready_o;
  logic [EVNT_WIDTH-1:0] evt_data_i;
  logic [NB_CORES-1:0]   pop_req_i;
  logic [NB_CORES-1:0]   pop_gnt_o;
  logic [NB_CORES-1:0]   pop_rvalid_o;
  logic [EVNT_WIDTH:0]   pop_rdata_o;

  modport slave (
    input  evt_valid_i, evt_data_i, pop_req_i,
    output evt_ready_o, pop_gnt_o, pop_rvalid_o, pop_rdata_o
  );

  modport master (
    output evt_valid_i, evt_data_i, pop_req_i,
    input  evt_ready_o, pop_gnt_o, pop_rvalid_o, pop_rdata_o
  );

endinterface

// File: rtl/event_unit_soc_evt_fifo_rr_arb.sv
// Round-robin arbiter: one-hot grant in the request cycle, priority moves past the winner.
module event_unit_rr_arb #(
  parameter int NB_REQ = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NB_REQ-1:0] req_i,
  output logic [NB_REQ-1:0] gnt_o
);

  localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] idx;
  logic             found;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NB_REQ) s -= NB_REQ;
    return IDX_W'(s);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int off = 0; off < NB_REQ; off++) begin
      idx = wrap_add(ptr_q, off);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = wrap_add(idx, 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni)     ptr_q <= '0;
    else if (found)  ptr_q <= ptr_d;
  end

endmodule

// File: rtl/event_unit_soc_evt_fifo.sv
// SoC peripheral event FIFO: buffers event IDs, flags non-empty to the cluster,
// and serves arbitrated pops from up to NB_CORES cores.
module event_unit_soc_evt_fifo
  import event_unit_pkg::*;
#(
  parameter int NB_CORES     = 8,
  parameter int EVNT_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int DROP_ON_FULL = FIFO_MODE_BACKPRESSURE,
  parameter int DROP_CNT_W   = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  event_unit_soc_evt_fifo_if.slave          bus,
  input  logic                              flush_i,
  input  logic                              clr_ovf_i,
  output logic                              fifo_event_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o,
  output logic                              overflow_o,
  output logic [DROP_CNT_W-1:0]             drop_cnt_o
);

  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1);
  localparam bit DROP_MODE = (DROP_ON_FULL == FIFO_MODE_DROP);

  typedef struct packed {
    logic                  hit;
    logic [EVNT_WIDTH-1:0] id;
  } resp_t;

  logic [EVNT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q;
  logic                  overflow_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic [NB_CORES-1:0]   rvalid_q;
  resp_t                 rdata_q;

  logic [NB_CORES-1:0]   gnt;
  logic                  full, empty, ready;
  logic                  push_try, push_do, pop_do, drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  event_unit_rr_arb #(.NB_REQ(NB_CORES)) u_arb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .req_i (bus.pop_req_i),
    .gnt_o (gnt)
  );

  // Ready comes from registered level only, so a same-cycle pop never feeds back into it.
  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign ready = DROP_MODE ? 1'b1 : !full;

  assign push_try = bus.evt_valid_i && ready;
  assign pop_do   = (|gnt) && !empty && !flush_i;
  assign push_do  = push_try && !flush_i && (!full || pop_do);
  assign drop     = DROP_MODE && push_try && full && !pop_do && !flush_i;

  always_ff @(posedge clk_i) begin
    // NOTE: storage has no reset; level and pointers decide which entries are meaningful.
    if (rst_ni && push_do) mem_q[wr_ptr_q] <= bus.evt_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push_do) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop_do)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        unique case ({push_do, pop_do})
          2'b10:   level_q <= level_q + 1'b1;
          2'b01:   level_q <= level_q - 1'b1;
          default: ;
        endcase
      end

      // A drop in the clearing cycle wins, leaving the counter at exactly one.
      if (drop)           overflow_q <= 1'b1;
      else if (clr_ovf_i) overflow_q <= 1'b0;

      if (clr_ovf_i)                                     drop_cnt_q <= drop ? DROP_CNT_W'(1) : '0;
      else if (drop && drop_cnt_q != {DROP_CNT_W{1'b1}}) drop_cnt_q <= drop_cnt_q + 1'b1;

      rvalid_q <= gnt;
      if (|gnt) begin
        rdata_q.hit <= pop_do;
        rdata_q.id  <= pop_do ? mem_q[rd_ptr_q] : '0;
      end
    end
  end

  assign bus.evt_ready_o  = ready;
  assign bus.pop_gnt_o    = gnt;
  assign bus.pop_rvalid_o = rvalid_q;
  assign bus.pop_rdata_o  = rdata_q;
  assign fifo_event_o     = !empty;
  assign fifo_level_o     = level_q;
  assign overflow_o       = overflow_q;
  assign drop_cnt_o       = drop_cnt_q;

endmodule

// File: tb/tb_event_unit_soc_evt_fifo.sv
// Directed bench: backpressure and drop FIFOs of depth 8 plus a depth-5 FIFO, all on shared stimulus.
module tb_event_unit_soc_evt_fifo;
  import event_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic [7:0] pop_req;
  logic       flush, clr_ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  event_unit_soc_evt_fifo_if #(.NB_CORES(8), .EVNT_WIDTH(8)) if_bp ();
  event_unit_soc_evt_fifo_if #(.NB_CORES(8), .EVNT_WIDTH(8)) if_dr ();
  event_unit_soc_evt_fifo_if #(.NB_CORES(8), .EVNT_WIDTH(8)) if_w5 ();

  assign if_bp.evt_valid_i = evt_valid;
  assign if_bp.evt_data_i  = evt_data;
  assign if_bp.pop_req_i   = pop_req;
  assign if_dr.evt_valid_i = evt_valid;
  assign if_dr.evt_data_i  = evt_data;
  assign if_dr.pop_req_i   = pop_req;
  assign if_w5.evt_valid_i = evt_valid;
  assign if_w5.evt_data_i  = evt_data;
  assign if_w5.pop_req_i   = pop_req;

  logic        ev_bp, ev_dr, ev_w5, ovf_bp, ovf_dr, ovf_w5;
  logic [3:0]  lvl_bp, lvl_dr;
  logic [2:0]  lvl_w5;
  logic [15:0] cnt_bp, cnt_dr, cnt_w5;

  event_unit_soc_evt_fifo #(.FIFO_DEPTH(8), .DROP_ON_FULL(FIFO_MODE_BACKPRESSURE)) dut_bp (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_bp), .flush_i(flush), .clr_ovf_i(clr_ovf),
    .fifo_event_o(ev_bp), .fifo_level_o(lvl_bp), .overflow_o(ovf_bp), .drop_cnt_o(cnt_bp));

  event_unit_soc_evt_fifo #(.FIFO_DEPTH(8), .DROP_ON_FULL(FIFO_MODE_DROP)) dut_dr (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_dr), .flush_i(flush), .clr_ovf_i(clr_ovf),
    .fifo_event_o(ev_dr), .fifo_level_o(lvl_dr), .overflow_o(ovf_dr), .drop_cnt_o(cnt_dr));

  event_unit_soc_evt_fifo #(.FIFO_DEPTH(5), .DROP_ON_FULL(FIFO_MODE_BACKPRESSURE)) dut_w5 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_w5), .flush_i(flush), .clr_ovf_i(clr_ovf),
    .fifo_event_o(ev_w5), .fifo_level_o(lvl_w5), .overflow_o(ovf_w5), .drop_cnt_o(cnt_w5));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; evt_valid = 1'b0; pop_req = '0; flush = 1'b0; clr_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [8:0] resp(input logic hit, input logic [7:0] id);
    evt_resp_t r;
    r.hit = hit;
    r.id  = id;
    return r;
  endfunction

  logic [7:0] exp_g [6];

  initial begin
    // Reset held two cycles with a valid event on the link: nothing may be written.
    rst_n = 1'b0; evt_valid = 1'b1; evt_data = 8'hAA; pop_req = '0; flush = 1'b0; clr_ovf = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1; evt_valid = 1'b0;
    check("rst_level",  lvl_bp, 0);
    check("rst_ready",  if_bp.evt_ready_o, 1);
    check("rst_event",  ev_bp, 0);
    check("rst_rvalid", if_bp.pop_rvalid_o, 0);
    check("rst_rdata",  if_bp.pop_rdata_o, 0);
    check("rst_ovf",    ovf_dr, 0);
    check("rst_cnt",    cnt_dr, 0);

    // Ordering: three pushes, core 2 pops four times.
    evt_valid = 1'b1;
    evt_data = 8'h11; tick();
    evt_data = 8'h22; tick();
    evt_data = 8'h33; tick();
    evt_valid = 1'b0;
    check("ord_level", lvl_bp, 3);
    check("ord_event", ev_bp, 1);
    pop_req = 8'h04;
    #1 check("ord_gnt", if_bp.pop_gnt_o, 8'h04);
    tick(); check("ord_rv0", if_bp.pop_rvalid_o, 8'h04); check("ord_rd0", if_bp.pop_rdata_o, resp(1'b1, 8'h11));
    tick(); check("ord_rd1", if_bp.pop_rdata_o, resp(1'b1, 8'h22));
    tick(); check("ord_rd2", if_bp.pop_rdata_o, resp(1'b1, 8'h33));
    check("ord_event_off", ev_bp, 0);
    tick(); check("ord_rd_empty", if_bp.pop_rdata_o, resp(1'b0, 8'h00));
    check("ord_rv_empty", if_bp.pop_rvalid_o, 8'h04);
    pop_req = '0;
    tick(); check("ord_rv_pulse", if_bp.pop_rvalid_o, 0);
    check("ord_rd_hold", if_bp.pop_rdata_o, resp(1'b0, 8'h00));

    // Backpressure: ten pushes into depth 8, the last two stall until core 0 pops.
    do_reset();
    evt_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      evt_data = 8'h40 + 8'(i);
      tick();
    end
    evt_data = 8'h48;
    check("bp_full_level", lvl_bp, 8);
    check("bp_full_ready", if_bp.evt_ready_o, 0);
    tick(); tick();
    check("bp_stall_level", lvl_bp, 8);
    pop_req = 8'h01; tick(); pop_req = '0;
    check("bp_pop0", if_bp.pop_rdata_o, resp(1'b1, 8'h40));
    check("bp_lvl7", lvl_bp, 7);
    check("bp_ready7", if_bp.evt_ready_o, 1);
    tick(); evt_data = 8'h49;
    check("bp_refill48", lvl_bp, 8);
    pop_req = 8'h01; tick(); pop_req = '0;
    check("bp_pop1", if_bp.pop_rdata_o, resp(1'b1, 8'h41));
    tick(); evt_valid = 1'b0;
    check("bp_refill49", lvl_bp, 8);
    pop_req = 8'h01;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("bp_drain", if_bp.pop_rdata_o, resp(1'b1, 8'h42 + 8'(i)));
    end
    pop_req = '0;
    check("bp_empty", lvl_bp, 0);

    // Drop mode: two drops, clear racing a drop, then full + pop accepts the push.
    do_reset();
    evt_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      evt_data = 8'h50 + 8'(i);
      tick();
    end
    check("dr_level", lvl_dr, 8);
    check("dr_ovf",   ovf_dr, 1);
    check("dr_cnt2",  cnt_dr, 2);
    check("dr_ready", if_dr.evt_ready_o, 1);
    evt_data = 8'h5A; clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("dr_clr_race_cnt", cnt_dr, 1);
    check("dr_clr_race_ovf", ovf_dr, 1);
    evt_valid = 1'b0; clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("dr_clr_cnt", cnt_dr, 0);
    check("dr_clr_ovf", ovf_dr, 0);
    evt_valid = 1'b1; evt_data = 8'h77; pop_req = 8'h02; tick();
    evt_valid = 1'b0; pop_req = '0;
    check("dr_fullpop_rd",  if_dr.pop_rdata_o, resp(1'b1, 8'h50));
    check("dr_fullpop_lvl", lvl_dr, 8);
    check("dr_fullpop_cnt", cnt_dr, 0);
    pop_req = 8'h02;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("dr_drain", if_dr.pop_rdata_o, (i < 7) ? resp(1'b1, 8'h51 + 8'(i)) : resp(1'b1, 8'h77));
    end
    pop_req = '0;

    // Arbitration: cores 0, 3, 7 request continuously over six entries.
    do_reset();
    evt_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      evt_data = 8'h60 + 8'(i);
      tick();
    end
    evt_valid = 1'b0;
    exp_g[0] = 8'h01; exp_g[1] = 8'h08; exp_g[2] = 8'h80;
    exp_g[3] = 8'h01; exp_g[4] = 8'h08; exp_g[5] = 8'h80;
    pop_req = 8'h89;
    for (int i = 0; i < 6; i++) begin
      #1 check("arb_gnt", if_bp.pop_gnt_o, exp_g[i]);
      tick();
      check("arb_rvalid", if_bp.pop_rvalid_o, exp_g[i]);
      check("arb_rdata",  if_bp.pop_rdata_o, resp(1'b1, 8'h60 + 8'(i)));
    end
    pop_req = 8'h08;
    #1 check("arb_gnt_empty", if_bp.pop_gnt_o, 8'h08);
    tick(); pop_req = '0;
    check("arb_rv_empty", if_bp.pop_rvalid_o, 8'h08);
    check("arb_rd_empty", if_bp.pop_rdata_o, resp(1'b0, 8'h00));

    // Wrap on depth 5: thirteen pushes interleaved with pops, order preserved.
    do_reset();
    evt_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      evt_data = 8'h70 + 8'(i);
      tick();
    end
    pop_req = 8'h02;
    for (int i = 0; i < 10; i++) begin
      evt_data = 8'h73 + 8'(i);
      tick();
      check("w5_inter", if_w5.pop_rdata_o, resp(1'b1, 8'h70 + 8'(i)));
    end
    evt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w5_tail", if_w5.pop_rdata_o, resp(1'b1, 8'h7A + 8'(i)));
    end
    pop_req = '0;
    check("w5_empty", lvl_w5, 0);

    // Flush overrides a same-cycle push and pop.
    evt_valid = 1'b1;
    evt_data = 8'h80; tick();
    evt_data = 8'h81; tick();
    check("fl_pre_level", lvl_w5, 2);
    evt_data = 8'h82; flush = 1'b1; pop_req = 8'h02; tick();
    flush = 1'b0; evt_valid = 1'b0; pop_req = '0;
    check("fl_level",  lvl_w5, 0);
    check("fl_event",  ev_w5, 0);
    check("fl_rvalid", if_w5.pop_rvalid_o, 8'h02);
    check("fl_rdata",  if_w5.pop_rdata_o, resp(1'b0, 8'h00));
    evt_valid = 1'b1; evt_data = 8'h90; tick();
    evt_valid = 1'b0; pop_req = 8'h02; tick(); pop_req = '0;
    check("fl_after", if_w5.pop_rdata_o, resp(1'b1, 8'h90));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
